// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the two-port system bus arbiter.
package sys_bus_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 16;
    localparam int unsigned WCNT_W = 4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Counter preload so that WAIT lasts exactly ws cycles; unused when ws is 0.
    function automatic logic [WCNT_W-1:0] wait_load_value(input int unsigned ws);
        if (ws == 0) begin
            return '0;
        end
        return WCNT_W'(ws - 1);
    endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Requester and memory-side signal bundle for sys_bus_arbiter.
interface sys_bus_arbiter_if
    import sys_bus_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) ();

    logic          req0;
    logic          req1;
    logic          rw0;
    logic          rw1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;
    logic          sys_strobe;
    logic          sys_rw;
    logic [AW-1:0] sys_addr;
    logic [DW-1:0] sys_wdata;
    logic          sys_data_oe;
    logic [DW-1:0] sys_data_in;

    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, sys_data_in,
        output gnt0, gnt1, done0, done1, rdata,
        output sys_strobe, sys_rw, sys_addr, sys_wdata, sys_data_oe
    );

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, sys_data_in,
        input  gnt0, gnt1, done0, done1, rdata,
        input  sys_strobe, sys_rw, sys_addr, sys_wdata, sys_data_oe
    );

endinterface

// File: rtl/sys_wait_ctr.sv
// 4-bit loadable down-counter that saturates at zero; zero flag is registered.
module sys_wait_ctr
    import sys_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WCNT_W-1:0] load_value,
    output logic              zero
);

    logic [WCNT_W-1:0] cnt;
    logic [WCNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = load_value;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - WCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else begin
            cnt  <= cnt_nxt;
            zero <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-port system bus arbiter with strobe/wait/done memory handshake.
// Define SYS_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned WAITSTATES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sys_bus_arbiter_if.slave     bus
);

    state_t        state;
    state_t        state_nxt;
    logic          win;
    logic          win_nxt;
    logic          pick;
    logic          ctr_load;
    logic          ctr_zero;

    logic          sel_rw;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          gnt0_d;
    logic          gnt1_d;
    logic          done0_d;
    logic          done1_d;
    logic          strobe_d;
    logic          rw_d;
    logic          oe_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] rdata_d;

`ifdef SYS_ARB_ROUND_ROBIN_EN
    logic last;

    always_comb begin
        pick = PORT0;
        if (bus.req0 && bus.req1) begin
            pick = ~last;
        end else if (bus.req1) begin
            pick = PORT1;
        end
    end

    // Pointer remembers the port granted most recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= PORT1;
        end else if (state == ST_IDLE && state_nxt == ST_STROBE) begin
            last <= win_nxt;
        end
    end
`else
    always_comb begin
        pick = bus.req0 ? PORT0 : PORT1;
    end
`endif

    assign ctr_load = (state == ST_STROBE);

    sys_wait_ctr u_wait_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ctr_load),
        .load_value (wait_load_value(WAITSTATES)),
        .zero       (ctr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            win   <= PORT0;
        end else begin
            state <= state_nxt;
            win   <= win_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        case (state)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_nxt = ST_STROBE;
                    win_nxt   = pick;
                end
            end
            ST_STROBE: state_nxt = (WAITSTATES == 0) ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (ctr_zero) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_rw    = (win_nxt == PORT1) ? bus.rw1    : bus.rw0;
        sel_addr  = (win_nxt == PORT1) ? bus.addr1  : bus.addr0;
        sel_wdata = (win_nxt == PORT1) ? bus.wdata1 : bus.wdata0;
    end

    // Outputs are computed from the next state so they register with no added latency.
    always_comb begin
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        strobe_d = 1'b0;
        rw_d     = 1'b0;
        oe_d     = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        rdata_d  = bus.rdata;
        if (state_nxt != ST_IDLE) begin
            gnt0_d = (win_nxt == PORT0);
            gnt1_d = (win_nxt == PORT1);
            if (state == ST_IDLE) begin
                rw_d    = sel_rw;
                addr_d  = sel_addr;
                wdata_d = sel_wdata;
            end else begin
                rw_d    = bus.sys_rw;
                addr_d  = bus.sys_addr;
                wdata_d = bus.sys_wdata;
            end
            oe_d = ~rw_d;
        end
        strobe_d = (state_nxt == ST_STROBE);
        done0_d  = (state_nxt == ST_DONE) && (win_nxt == PORT0);
        done1_d  = (state_nxt == ST_DONE) && (win_nxt == PORT1);
        if (state_nxt == ST_DONE && state != ST_DONE && bus.sys_rw) begin
            rdata_d = bus.sys_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.gnt0        <= 1'b0;
            bus.gnt1        <= 1'b0;
            bus.done0       <= 1'b0;
            bus.done1       <= 1'b0;
            bus.sys_strobe  <= 1'b0;
            bus.sys_rw      <= 1'b0;
            bus.sys_data_oe <= 1'b0;
            bus.sys_addr    <= '0;
            bus.sys_wdata   <= '0;
            bus.rdata       <= '0;
        end else begin
            bus.gnt0        <= gnt0_d;
            bus.gnt1        <= gnt1_d;
            bus.done0       <= done0_d;
            bus.done1       <= done1_d;
            bus.sys_strobe  <= strobe_d;
            bus.sys_rw      <= rw_d;
            bus.sys_data_oe <= oe_d;
            bus.sys_addr    <= addr_d;
            bus.sys_wdata   <= wdata_d;
            bus.rdata       <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Scoreboard bench for sys_bus_arbiter (WAITSTATES=2 main instance, WAITSTATES=0 side instance).
module tb_sys_bus_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned WS = 2;

    typedef struct {
        bit          port;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        exp_q[$];
    logic [15:0] model_rdata;

    sys_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    sys_bus_arbiter_if #(.AW(AW), .DW(DW)) bus_z ();

    sys_bus_arbiter #(.AW(AW), .DW(DW), .WAITSTATES(WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sys_bus_arbiter #(.AW(AW), .DW(DW), .WAITSTATES(0)) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any completion on the main instance.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (bus.gnt0 || bus.gnt1) begin
                check("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'(0));
            end
            if (bus.done0 || bus.done1) begin
                check("done_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("done_port", 32'(bus.done1), 32'(e.port));
                    check("done_both", 32'(bus.done0 & bus.done1), 32'(0));
                    check("done_cyc", 32'(cyc), 32'(e.cyc));
                    check("rdata", 32'(bus.rdata), 32'(e.rdata));
                end
            end
        end
    endtask

    task automatic set_req(input bit port, input bit val);
        if (port) bus.req1 = val;
        else      bus.req0 = val;
    endtask

    task automatic run_txn(input bit port, input bit rd, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] din, input bit drop_early);
        exp_t e;
        bit   seen;
        tick();
        if (port) begin
            bus.rw1 = rd; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.rw0 = rd; bus.addr0 = addr; bus.wdata0 = wdata;
        end
        set_req(port, 1'b1);
        bus.sys_data_in = din;
        if (rd) model_rdata = din;
        e.port  = port;
        e.rdata = model_rdata;
        e.cyc   = cyc + 2 + int'(WS);
        exp_q.push_back(e);
        tick();
        check("strobe", 32'(bus.sys_strobe), 32'(1));
        check("sys_rw", 32'(bus.sys_rw), 32'(rd));
        check("sys_addr", 32'(bus.sys_addr), 32'(addr));
        check("sys_wdata", 32'(bus.sys_wdata), 32'(wdata));
        check("gnt", 32'(port ? bus.gnt1 : bus.gnt0), 32'(1));
        check("oe_strobe", 32'(bus.sys_data_oe), 32'(!rd));
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (i == 0 && drop_early) set_req(port, 1'b0);
            if (port ? bus.done1 : bus.done0) begin
                seen = 1'b1;
                check("oe_done", 32'(bus.sys_data_oe), 32'(!rd));
                set_req(port, 1'b0);
            end
        end
        set_req(port, 1'b0);
        check("done_seen", 32'(seen), 32'(1));
        tick();
        check("idle_gnt", 32'({bus.gnt0, bus.gnt1}), 32'(0));
        check("idle_addr", 32'(bus.sys_addr), 32'(0));
        check("idle_oe", 32'(bus.sys_data_oe), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   k;
        int   n_done;
        exp_t e;

        rst_n = 1'b0;
        model_rdata = '0;
        {bus.req0, bus.req1, bus.rw0, bus.rw1} = '0;
        {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1, bus.sys_data_in} = '0;
        {bus_z.req0, bus_z.req1, bus_z.rw0, bus_z.rw1} = '0;
        {bus_z.addr0, bus_z.addr1, bus_z.wdata0, bus_z.wdata1, bus_z.sys_data_in} = '0;

        repeat (3) @(negedge clk);
        check("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'(0));
        check("rst_strobe", 32'(bus.sys_strobe), 32'(0));
        check("rst_rdata", 32'(bus.rdata), 32'(0));
        check("rst_done", 32'({bus.done0, bus.done1}), 32'(0));
        rst_n = 1'b1;
        tick();

        // Read on port 0, write on port 1, then read with Req0 dropped mid-WAIT
        run_txn(1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 1'b0);
        run_txn(1'b1, 1'b0, 16'h0010, 16'h1234, 16'hDEAD, 1'b0);
        run_txn(1'b0, 1'b1, 16'h0044, 16'h0000, 16'hCAFE, 1'b1);

        // Reset while in WAIT aborts with no Done
        tick();
        bus.rw0 = 1'b1; bus.addr0 = 16'h0080; bus.sys_data_in = 16'h7777;
        bus.req0 = 1'b1;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'(0));
        check("arst_strobe", 32'(bus.sys_strobe), 32'(0));
        check("arst_addr", 32'(bus.sys_addr), 32'(0));
        check("arst_oe", 32'(bus.sys_data_oe), 32'(0));
        check("arst_rdata", 32'(bus.rdata), 32'(0));
        bus.req0 = 1'b0;
        model_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'(0));
        run_txn(1'b1, 1'b1, 16'h0020, 16'h0000, 16'h5A5A, 1'b0);

        // Both ports held high for four back-to-back transactions
        tick();
        bus.rw0 = 1'b1; bus.addr0 = 16'h0100;
        bus.rw1 = 1'b1; bus.addr1 = 16'h0200;
        bus.sys_data_in = 16'h4321;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        model_rdata = 16'h4321;
        k = cyc;
        for (int i = 0; i < 4; i++) begin
`ifdef SYS_ARB_ROUND_ROBIN_EN
            e.port = (i % 2) == 1;
`else
            e.port = 1'b0;
`endif
            e.rdata = model_rdata;
            e.cyc   = k + 4 + 5 * i;
            exp_q.push_back(e);
        end
        n_done = 0;
        for (int i = 0; i < 40 && n_done < 4; i++) begin
            tick();
            if (bus.done0 || bus.done1) begin
                n_done++;
                if (n_done == 4) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("arb_done_count", 32'(n_done), 32'(4));
        tick();
        check("arb_idle_gnt", 32'({bus.gnt0, bus.gnt1}), 32'(0));
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        // Zero wait states: STROBE goes straight to DONE
        tick();
        bus_z.rw0 = 1'b1; bus_z.addr0 = 16'h0040; bus_z.sys_data_in = 16'h0F0F;
        bus_z.req0 = 1'b1;
        tick();
        check("z_strobe", 32'(bus_z.sys_strobe), 32'(1));
        check("z_gnt", 32'(bus_z.gnt0), 32'(1));
        check("z_addr", 32'(bus_z.sys_addr), 32'(16'h0040));
        check("z_done_early", 32'(bus_z.done0), 32'(0));
        tick();
        check("z_done", 32'(bus_z.done0), 32'(1));
        check("z_strobe_off", 32'(bus_z.sys_strobe), 32'(0));
        check("z_rdata", 32'(bus_z.rdata), 32'(16'h0F0F));
        bus_z.req0 = 1'b0;
        tick();
        check("z_idle_gnt", 32'(bus_z.gnt0), 32'(0));
        check("z_done_off", 32'(bus_z.done0), 32'(0));
        check("z_rdata_hold", 32'(bus_z.rdata), 32'(16'h0F0F));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sys_bus_arbiter.md
SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 16, address width; DW, 16, data width; WAITSTATES, 2, memory wait cycles after strobe (0..15).
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Req0/Req1  input  1  transaction request, port 0 (cache controller) / port 1 (write buffer).
REQ-005 RW0/RW1  input  1  1 = read, 0 = write, per port.
REQ-006 Addr0/Addr1  input  AW  address per port; WData0/WData1  input  DW  write data per port.
REQ-007 Gnt0/Gnt1  output  1  port owns system bus; Done0/Done1  output  1  one-cycle completion pulse.
REQ-008 RData  output  DW  registered read data, shared by both ports.
REQ-009 SysStrobe  output  1; SysRW  output  1; SysAddr  output  AW; SysWData  output  DW; SysDataOE  output  1 (drive write data); SysDataIn  input  DW.

Function
REQ-010 FSM states SHALL be IDLE, STROBE, WAIT, DONE; encoding from shared package.
REQ-011 IDLE: sample Req0/Req1; if any high, latch winner, go STROBE next edge; else stay IDLE.
REQ-012 STROBE: exactly one cycle; SysStrobe=1, SysRW=RW of winner; load wait counter with WAITSTATES-1; go WAIT, or DONE if WAITSTATES=0.
REQ-013 WAIT: decrement counter each cycle; go DONE on the edge where counter is 0; stays exactly WAITSTATES cycles.
REQ-014 DONE: exactly one cycle; Done of winner = 1; return to IDLE.
REQ-015 Latency: Req sampled in IDLE at cycle N -> SysStrobe at N+1 -> Done at N+2+WAITSTATES.
REQ-016 Gnt of winner SHALL be 1 from STROBE through DONE inclusive; never both Gnt high.
REQ-017 SysAddr/SysWData/SysRW SHALL mux winner inputs while Gnt high; 0 otherwise.
REQ-018 SysDataOE=1 from STROBE through DONE only for writes.
REQ-019 For reads, RData SHALL capture SysDataIn on the edge entering DONE; holds until next read capture; unchanged by writes.
REQ-020 Req, RW, Addr, WData SHALL be ignored outside IDLE; dropping Req mid-transaction does not abort it.
REQ-021 Req still high in IDLE after DONE SHALL start a new transaction (requester drops Req during its Done cycle).
REQ-022 Simultaneous Req0 and Req1 in IDLE: winner per REQ-026/REQ-027.

Reset
REQ-023 Reset low SHALL immediately force IDLE, all outputs 0, RData 0, counter 0, round-robin pointer to "last = port 1".
REQ-024 Reset mid-transaction SHALL abort it with no Done pulse; first IDLE sample follows first edge after release.

Configuration
REQ-025 Macro SYS_ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-026 Defined: on simultaneous requests, grant port not granted last; pointer updates on entering STROBE.
REQ-027 Undefined: fixed priority, port 0 always wins; no pointer register exists.

Structure
REQ-028 Package sys_bus_pkg SHALL hold state typedef/encoding, port-index constants, AW/DW defaults.
REQ-029 Sub-module sys_wait_ctr (4-bit loadable down-counter: Load, LoadValue, Zero) SHALL implement the wait count.

Verification
REQ-030 WAITSTATES=2, Req0 read Addr0=0x0040, SysDataIn=0xBEEF -> SysStrobe at N+1, Done0 at N+4, RData=0xBEEF.
REQ-031 Req1 write Addr1=0x0010 WData1=0x1234 -> SysRW=0, SysDataOE=1 STROBE..DONE, SysWData=0x1234, Done1 at N+4, RData unchanged.
REQ-032 Req0 and Req1 held high for 4 transactions, RR enabled -> grants 0,1,0,1; RR disabled -> 0,0,0,0.
REQ-033 WAITSTATES=0 -> STROBE then DONE directly, Done at N+2.
REQ-034 Reset low during WAIT -> outputs 0 same cycle, no Done; after release Req1 served normally.
REQ-035 Req0 dropped during WAIT -> transaction completes, Done0 still pulses once.
